fp16_accumulator: RTL and testbench

//  Downstream consumer of Floating_point_Unit results. Sums a stream of FP16 values
//  (IEEE binary16: 1 sign, 5 exp with bias 15, 10 mantissa) into one FP16 result per group.

---
 rtl/fp16_pkg.sv | 39 +++
 rtl/fp16_add.sv | 118 +++++++++++
 rtl/fp16_accumulator.sv | 111 +++++++++++
 tb/tb_fp16_accumulator.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// FP16 shared definitions: field widths, special encodings, accumulator
// state type and small helpers used by the adder and the accumulator.
package fp16_pkg;

    localparam int FP16_W   = 16;
    localparam int EXP_W    = 5;
    localparam int MAN_W    = 10;
    localparam int EXP_BIAS = 15;

    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1f;

    localparam logic [FP16_W-1:0] FP16_PZERO = 16'h0000;
    localparam logic [FP16_W-1:0] FP16_NZERO = 16'h8000;
    localparam logic [FP16_W-1:0] FP16_PINF  = 16'h7C00;
    localparam logic [FP16_W-1:0] FP16_NINF  = 16'hFC00;
    localparam logic [FP16_W-1:0] FP16_QNAN  = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    // Denormals become zero of the same sign.
    function automatic logic [15:0] fp16_ftz(input logic [15:0] x);
        return (x[14:10] == 5'd0) ? {x[15], 15'd0} : x;
    endfunction

    // Leading-zero count of a 14-bit value (result unused for zero).
    function automatic logic [3:0] lzc14(input logic [13:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (v[i]) n = 4'(13 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational IEEE binary16 adder, RNE, denormals flushed to zero.
// Ports: i_a, i_b (operands), o_sum (result).
module fp16_add
    import fp16_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum
);

    logic        w_sa, w_sb;
    logic [4:0]  w_ea, w_eb;
    logic [9:0]  w_fa, w_fb;

    assign {w_sa, w_ea, w_fa} = i_a;
    assign {w_sb, w_eb, w_fb} = i_b;

    logic w_a_zero, w_b_zero;
    logic w_a_nan,  w_b_nan;
    logic w_a_inf,  w_b_inf;

    assign w_a_zero = (w_ea == 5'd0);
    assign w_b_zero = (w_eb == 5'd0);
    assign w_a_nan  = (w_ea == EXP_MAX) &&  (|w_fa);
    assign w_b_nan  = (w_eb == EXP_MAX) &&  (|w_fb);
    assign w_a_inf  = (w_ea == EXP_MAX) && !(|w_fa);
    assign w_b_inf  = (w_eb == EXP_MAX) && !(|w_fb);

    // Larger magnitude goes on the "l" side; it sets the result sign.
    logic        w_swap;
    logic        w_sub;
    logic        w_l_s;
    logic [4:0]  w_l_e, w_s_e, w_d;
    logic [9:0]  w_l_f, w_s_f;

    assign w_swap = ({w_eb, w_fb} > {w_ea, w_fa});
    assign w_sub  = w_sa ^ w_sb;
    assign w_l_s  = w_swap ? w_sb : w_sa;
    assign w_l_e  = w_swap ? w_eb : w_ea;
    assign w_l_f  = w_swap ? w_fb : w_fa;
    assign w_s_e  = w_swap ? w_ea : w_eb;
    assign w_s_f  = w_swap ? w_fa : w_fb;
    assign w_d    = w_l_e - w_s_e;

    // 14-bit working format: hidden, 10 fraction, guard, round, sticky.
    logic [13:0] w_big, w_small, w_mask, w_aln;

    assign w_big   = {1'b1, w_l_f, 3'b000};
    assign w_small = {1'b1, w_s_f, 3'b000};
    assign w_mask  = (14'd1 << w_d) - 14'd1;
    assign w_aln   = (w_d >= 5'd13) ? 14'd1 :
                     ((w_small >> w_d) |
                      {13'd0, |(w_small & w_mask)});

    logic [14:0] w_sum15;
    logic [13:0] w_diff;
    logic [3:0]  w_lz;

    assign w_sum15 = {1'b0, w_big} + {1'b0, w_aln};
    assign w_diff  = w_big - w_aln;
    assign w_lz    = lzc14(w_diff);

    logic [13:0]       w_norm;
    logic signed [6:0] w_nexp;

    always_comb begin
        w_norm = 14'd0;
        w_nexp = 7'sd0;
        if (w_sub) begin
            w_norm = w_diff << w_lz;
            w_nexp = $signed({2'b00, w_l_e}) - $signed({3'b000, w_lz});
        end else if (w_sum15[14]) begin
            w_norm = {w_sum15[14:2], w_sum15[1] | w_sum15[0]};
            w_nexp = $signed({2'b00, w_l_e}) + 7'sd1;
        end else begin
            w_norm = w_sum15[13:0];
            w_nexp = $signed({2'b00, w_l_e});
        end
    end

    logic              w_rup;
    logic [11:0]       w_mrnd;
    logic signed [6:0] w_rexp;
    logic [9:0]        w_rfrac;

    assign w_rup   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_mrnd  = {1'b0, w_norm[13:3]} + {11'd0, w_rup};
    assign w_rexp  = w_nexp + (w_mrnd[11] ? 7'sd1 : 7'sd0);
    assign w_rfrac = w_mrnd[11] ? w_mrnd[10:1] : w_mrnd[9:0];

    // Underflow can only come from exact cancellation paths, so
    // testing the exponent before rounding is safe.
    always_comb begin
        o_sum = FP16_PZERO;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_sub)) begin
            o_sum = FP16_QNAN;
        end else if (w_a_inf) begin
            o_sum = {w_sa, EXP_MAX, 10'd0};
        end else if (w_b_inf) begin
            o_sum = {w_sb, EXP_MAX, 10'd0};
        end else if (w_a_zero && w_b_zero) begin
            o_sum = {w_sa & w_sb, 15'd0};
        end else if (w_a_zero) begin
            o_sum = i_b;
        end else if (w_b_zero) begin
            o_sum = i_a;
        end else if (w_sub && (w_diff == 14'd0)) begin
            o_sum = FP16_PZERO;
        end else if (w_nexp < 7'sd1) begin
            o_sum = FP16_PZERO;
        end else if (w_rexp >= 7'sd31) begin
            o_sum = {w_l_s, EXP_MAX, 10'd0};
        end else begin
            o_sum = {w_l_s, w_rexp[4:0], w_rfrac};
        end
    end

endmodule

// File: rtl/fp16_accumulator.sv
// Sums groups of FP16 elements into one FP16 result per group.
// Ports: clk, reset (async, low), clr, in_* stream, out_* result.
module fp16_accumulator
    import fp16_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_count
);

    if (DATA_WIDTH != 16) begin : g_bad_width
        $error("fp16_accumulator supports DATA_WIDTH = 16 only");
    end

    acc_state_t             r_state;
    logic [15:0]            r_acc;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic [CNT_WIDTH-1:0]   r_out_count;

    logic [15:0]            w_sum;
    logic [15:0]            w_next_acc;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;
    logic [CNT_WIDTH-1:0]   w_next_cnt;
    logic                   w_in_xfer;
    logic                   w_out_xfer;

    fp16_add u_add (
        .i_a   (r_acc),
        .i_b   (in_data),
        .o_sum (w_sum)
    );

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    // First element of a group starts the sum instead of adding to it.
    assign w_cnt_inc  = (r_count == '1) ? r_count :
                        r_count + CNT_WIDTH'(1);
    assign w_next_acc = (r_state == IDLE) ? fp16_ftz(in_data) : w_sum;
    assign w_next_cnt = (r_state == IDLE) ? CNT_WIDTH'(1) : w_cnt_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_acc       <= FP16_PZERO;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (clr) begin
            r_state     <= IDLE;
            r_acc       <= FP16_PZERO;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else begin
            unique case (r_state)
                IDLE, ACC: begin
                    if (w_in_xfer) begin
                        r_acc   <= w_next_acc;
                        r_count <= w_next_cnt;
                        if (in_last) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_next_acc;
                            r_out_count <= w_next_cnt;
                        end else begin
                            r_state <= ACC;
                        end
                    end
                end
                DONE: begin
                    if (w_out_xfer) begin
                        r_state     <= IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_fp16_accumulator.sv
// Self-checking bench for fp16_accumulator: directed groups plus
// random groups compared against a real-arithmetic reference model.
module tb_fp16_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_count;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] grp[$];

    fp16_accumulator #(.DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real h2r(input logic [15:0] h);
        real r;
        int  k;
        if (h[14:10] == 5'd0) return 0.0;
        r = 1.0 + real'(h[9:0]) / 1024.0;
        k = int'(h[14:10]) - 15;
        while (k > 0) begin r = r * 2.0; k--; end
        while (k < 0) begin r = r / 2.0; k++; end
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2h(input real v);
        logic s;
        real  a, sc, fr;
        int   e, ip;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        sc = a * 1024.0;
        ip = $rtoi(sc);
        fr = sc - real'(ip);
        if (fr > 0.5 || (fr == 0.5 && (ip % 2) == 1)) ip++;
        if (ip == 2048) begin ip = 1024; e++; end
        if (e + 15 < 1) return 16'h0000;
        if (e + 15 >= 31) return s ? 16'hFC00 : 16'h7C00;
        return {s, 5'(e + 15), 10'(ip - 1024)};
    endfunction

    function automatic logic [15:0] ftz(input logic [15:0] x);
        return (x[14:10] == 5'd0) ? {x[15], 15'd0} : x;
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a,
                                            input logic [15:0] b);
        bit an, bn, ai, bi, az, bz;
        an = (a[14:10] == 5'h1f) && (a[9:0] != 0);
        bn = (b[14:10] == 5'h1f) && (b[9:0] != 0);
        ai = (a[14:10] == 5'h1f) && (a[9:0] == 0);
        bi = (b[14:10] == 5'h1f) && (b[9:0] == 0);
        az = (a[14:10] == 5'd0);
        bz = (b[14:10] == 5'd0);
        if (an || bn) return 16'h7E00;
        if (ai && bi && (a[15] != b[15])) return 16'h7E00;
        if (ai) return {a[15], 15'h7C00};
        if (bi) return {b[15], 15'h7C00};
        if (az && bz) return {a[15] & b[15], 15'd0};
        if (az) return b;
        if (bz) return a;
        return r2h(h2r(a) + h2r(b));
    endfunction

    function automatic logic [15:0] ref_group();
        logic [15:0] acc;
        acc = ftz(grp[0]);
        for (int i = 1; i < grp.size(); i++) acc = ref_add(acc, grp[i]);
        return acc;
    endfunction

    function automatic logic [15:0] rnd_h();
        logic       s;
        logic [9:0] m;
        int         sel;
        s   = 1'($urandom);
        m   = 10'($urandom);
        sel = $urandom_range(0, 39);
        if (sel == 0) return {s, 5'd0, m};
        if (sel == 1) return {s, 15'd0};
        if (sel == 2) return {s, 5'h1f, 10'd0};
        if (sel == 3) return {s, 5'h1f, m | 10'd1};
        if (sel < 10) return {s, 5'($urandom_range(1, 30)), m};
        return {s, 5'($urandom_range(10, 20)), m};
    endfunction

    // ---------------- drivers ----------------
    task automatic push(input logic [15:0] d, input bit last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_group(input string tag, input int stall,
                             input bit use_lit, input logic [15:0] lit);
        logic [15:0] exp_d;
        logic [7:0]  exp_c;
        exp_d = ref_group();
        exp_c = (grp.size() > 255) ? 8'hff : 8'(grp.size());
        for (int i = 0; i < grp.size(); i++) push(grp[i], i == grp.size() - 1);
        chk({tag, ":valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ":data"},  {16'd0, out_data},  {16'd0, exp_d});
        chk({tag, ":count"}, {24'd0, out_count}, {24'd0, exp_c});
        if (use_lit) chk({tag, ":lit"}, {16'd0, out_data}, {16'd0, lit});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, ":hold_rdy"},  {31'd0, in_ready}, 32'd0);
            chk({tag, ":hold_val"},  {31'd0, out_valid}, 32'd1);
            chk({tag, ":hold_data"}, {16'd0, out_data}, {16'd0, exp_d});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ":post_val"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ":post_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data",  {16'd0, out_data},  32'd0);
        chk("rst_count", {24'd0, out_count}, 32'd0);
        #10 reset = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", {31'd0, in_ready}, 32'd1);

        grp = '{16'h3C00, 16'h4000, 16'h4200};
        run_group("sum6", 0, 1, 16'h4600);
        grp = '{16'h7BFF, 16'h7BFF};
        run_group("ovf", 0, 1, 16'h7C00);
        grp = '{16'h7C00, 16'hFC00};
        run_group("infnan", 0, 1, 16'h7E00);
        grp = '{16'h3C00, 16'hBC00};
        run_group("cancel", 0, 1, 16'h0000);
        grp = '{16'h8000, 16'h8000};
        run_group("negz", 0, 1, 16'h8000);
        grp = '{16'h0001};
        run_group("denorm", 0, 1, 16'h0000);
        grp = '{16'h3C00, 16'h1000};
        run_group("tie_even", 0, 1, 16'h3C00);
        grp = '{16'h3C01, 16'h1000};
        run_group("tie_up", 0, 1, 16'h3C02);
        grp = '{16'h4000, 16'h3C00};
        run_group("stall5", 5, 1, 16'h4200);

        grp.delete();
        for (int i = 0; i < 300; i++) grp.push_back(16'h3C00);
        run_group("sat", 0, 1, 16'h5CB0);

        // reset while a finished result waits
        grp = '{16'h4400, 16'h4400};
        for (int i = 0; i < 2; i++) push(grp[i], i == 1);
        chk("rstd_pre", {16'd0, out_data}, 32'h4800);
        #2 reset = 1'b0;
        #1;
        chk("rstd_valid", {31'd0, out_valid}, 32'd0);
        chk("rstd_data",  {16'd0, out_data},  32'd0);
        chk("rstd_count", {24'd0, out_count}, 32'd0);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        chk("rstd_after", {31'd0, out_valid}, 32'd0);

        // reset mid-group; later elements arrive while in reset
        push(16'h4000, 1'b0);
        push(16'h4000, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("rstm_valid", {31'd0, out_valid}, 32'd0);
        chk("rstm_data",  {16'd0, out_data},  32'd0);
        in_valid = 1'b1;
        in_data  = 16'h4000;
        in_last  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("rstm_after", {31'd0, out_valid}, 32'd0);
        grp = '{16'h3C00, 16'h3C00, 16'h3C00};
        run_group("rstm_fresh", 0, 1, 16'h4200);

        // clr in ACC with a same-cycle last element
        push(16'h4200, 1'b0);
        push(16'h4200, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        in_last  = 1'b1;
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("clr_valid", {31'd0, out_valid}, 32'd0);
            chk("clr_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
        end
        grp = '{16'h4000, 16'h4000};
        run_group("clr_fresh", 0, 1, 16'h4400);

        for (int g = 0; g < 40; g++) begin
            int n;
            n = $urandom_range(1, 8);
            grp.delete();
            for (int i = 0; i < n; i++) grp.push_back(rnd_h());
            run_group($sformatf("rnd%0d", g), $urandom_range(0, 3),
                      1'b0, 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
